// File: rtl/qdivs_seq.sv
// Sequential sign-magnitude fixed-point divider.
// Restoring shift-subtract, one quotient bit per clock, MSB first.
// Saturates on quotient overflow and on divide-by-zero.
module qdivs_seq #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow,
    output logic         o_busy
);

    localparam int W  = N - 1 + Q;        // quotient register / iteration count
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N:0]    rem;
    logic [W-1:0]  quo;      // holds shifted dividend, quotient bits shift in from the LSB
    logic [N-2:0]  dvs;
    logic          sign;
    logic [CW-1:0] cnt;

    logic [N:0]    rem_sh;
    logic [N:0]    rem_nx;
    logic          ge;
    logic          ovf;
    logic [N-2:0]  mag;

    // One restoring step plus the saturation/sign fix-up of the final result
    always_comb begin
        rem_sh = {rem[N-1:0], quo[W-1]};
        ge     = rem[N] | (rem_sh >= {2'b00, dvs});
        rem_nx = ge ? (rem_sh - {2'b00, dvs}) : rem_sh;
        ovf    = |quo[W-1:N-1];
        mag    = ovf ? '1 : quo[N-2:0];
    end

    assign o_busy = (state == CALC);

    // Control FSM, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            sign           <= 1'b0;
            cnt            <= '0;
            o_quotient_out <= '0;
            o_complete     <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rem        <= '0;
                        quo        <= {i_dividend[N-2:0], {Q{1'b0}}};
                        dvs        <= i_divisor[N-2:0];
                        sign       <= i_dividend[N-1] ^ i_divisor[N-1];
                        cnt        <= '0;
                        o_overflow <= 1'b0;
                        // Zero divisor skips the iterations; DONE raises the flag next edge
                        state      <= (i_divisor[N-2:0] == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (!i_start) begin
                        state <= IDLE;
                    end else if (cnt == CW'(W)) begin
                        state          <= DONE;
                        o_complete     <= 1'b1;
                        o_overflow     <= ovf;
                        o_quotient_out <= {sign & (|mag), mag};
                    end else begin
                        rem <= rem_nx;
                        quo <= {quo[W-2:0], ge};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!i_start) begin
                        state      <= IDLE;
                        o_complete <= 1'b0;
                    end else if (!o_complete) begin
                        // Only reached on the divide-by-zero path
                        o_complete     <= 1'b1;
                        o_overflow     <= 1'b1;
                        o_quotient_out <= {sign, {(N-1){1'b1}}};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdivs_seq.sv
// Bench for qdivs_seq: directed vectors, scoreboard queue checked by a monitor.
module tb_qdivs_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dividend, divisor;
    logic        start;
    logic [31:0] quotient;
    logic        complete, overflow, busy;

    typedef struct {
        logic [31:0] q;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_c = 1'b0;

    qdivs_seq #(.N(32), .Q(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dividend(dividend), .i_divisor(divisor),
        .i_start(start), .o_quotient_out(quotient), .o_complete(complete),
        .o_overflow(overflow), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every rising o_complete pops one expected result
    always @(posedge clk) begin
        #1;
        if (complete && !prev_c) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_complete: got quotient %h, expected no completion", quotient);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        prev_c = complete;
    end

    // Accept edge happens at the next posedge; push expectation and wait for completion
    task automatic accept_and_wait(input logic [31:0] eq, input logic eov, input int elat);
        exp_t e;
        @(posedge clk);
        #1;
        e.q = eq; e.ov = eov; e.lat = elat; e.acc = cyc;
        exp_q.push_back(e);
        chk("busy_after_accept", 32'(busy), (elat > 1) ? 32'd1 : 32'd0);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        // operands change after acceptance must not matter
        @(negedge clk);
        dividend = 32'hDEADBEEF;
        divisor  = 32'h12345678;
        for (int i = 0; i < 100 && !complete; i++) @(negedge clk);
        if (!complete) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got complete=0 expected 1");
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic eov, input int elat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        accept_and_wait(eq, eov, elat);
    endtask

    task automatic drop;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("complete_low_after_drop", 32'(complete), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1;
        dividend = 32'h00060000; divisor = 32'h00020000;
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 32'h0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        // start already high: accepted at the first edge out of reset
        accept_and_wait(32'h00030000, 1'b0, 48);
        drop();

        op(32'h80018000, 32'h00008000, 32'h80030000, 1'b0, 48); drop();
        op(32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 48); drop();
        op(32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 48); drop();
        op(32'h40000000, 32'h00000100, 32'h7FFFFFFF, 1'b1, 48); drop();
        op(32'h00030000, 32'h80020000, 32'h80018000, 1'b0, 48);

        // Hold start in DONE: stays done, no restart
        repeat (5) @(negedge clk);
        chk("hold_complete", 32'(complete), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_quotient", quotient, 32'h80018000);
        drop();
        chk("retained_after_drop", quotient, 32'h80018000);

        // Abort at cycle 10 of CALC: nothing completes, result retained
        @(negedge clk);
        dividend = 32'h00060000; divisor = 32'h00020000; start = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        chk("abort_no_complete", 32'(complete), 32'd0);
        chk("abort_retained", quotient, 32'h80018000);

        // Divide by zero: one cycle, saturated, sign kept
        op(32'h80010000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1);
        drop();

        // Reset at cycle 20 of CALC clears everything
        @(negedge clk);
        dividend = 32'h00060000; divisor = 32'h00020000; start = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_quotient", quotient, 32'h0);
        chk("midrst_complete", 32'(complete), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Back-to-back: low one cycle, then a fresh operation
        op(32'h00060000, 32'h00020000, 32'h00030000, 1'b0, 48);
        drop();
        op(32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 48);
        drop();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
